// File: rtl/async_event_pkg.sv
// Shared types and helpers for the async event arbiter and related arbiters.
package async_event_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of pending, scanning from ptr upward and wrapping modulo num_req.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0]   pending,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          num_req
  );
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      cand = (32'(ptr) + off) % num_req;
      if (!res.found && (off < num_req) && pending[cand[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/async_event_arbiter_sync.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
module async_event_arbiter_sync #(
  parameter int unsigned           DATA_WIDTH = 1,
  parameter int unsigned           SYNC_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] stage_q [SYNC_DEPTH];

  // Shift chain; stage 0 is the only flop that sees the raw asynchronous input.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < SYNC_DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= i_data;
      for (int unsigned i = 1; i < SYNC_DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign o_data = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/async_event_arbiter.sv
// Synchronizes async request lines, latches rising edges as pending events and
// hands them one at a time to a single consumer with a round-robin grant.
module async_event_arbiter
  import async_event_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned SYNC_DEPTH = 2,
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_REQ-1:0]   i_async_req,
  output logic                 o_grant_valid,
  output logic [IDX_WIDTH-1:0] o_grant_idx,
  input  logic                 i_grant_ready,
  output logic [NUM_REQ-1:0]   o_pending,
  output logic [NUM_REQ-1:0]   o_overflow,
  input  logic                 i_overflow_clear
);

  logic [NUM_REQ-1:0]   sync_q;
  logic [NUM_REQ-1:0]   prev_q;
  logic [NUM_REQ-1:0]   rise_c;
  logic [NUM_REQ-1:0]   clr_c;
  logic [NUM_REQ-1:0]   pending_q;
  logic [NUM_REQ-1:0]   pending_d;
  logic [NUM_REQ-1:0]   overflow_q;
  logic [NUM_REQ-1:0]   overflow_d;

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic                 grant_valid_d;
  logic [IDX_WIDTH-1:0] grant_idx_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q;
  logic [IDX_WIDTH-1:0] rr_ptr_d;
  rr_pick_t             pick_c;

  // Bring all request lines into the clk domain.
  async_event_arbiter_sync #(
    .DATA_WIDTH (NUM_REQ),
    .SYNC_DEPTH (SYNC_DEPTH),
    .RESET_VAL  ('0)
  ) u_sync (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_data (i_async_req),
    .o_data (sync_q)
  );

  assign rise_c = sync_q & ~prev_q;

  // One-hot clear of the line whose grant is being accepted this cycle.
  always_comb begin
    clr_c = '0;
    if (o_grant_valid && i_grant_ready) begin
      clr_c[o_grant_idx] = 1'b1;
    end
  end

  // A new edge wins over a same-cycle accept; overflow clear wins over a same-cycle set.
  always_comb begin
    pending_d  = rise_c | (pending_q & ~clr_c);
    overflow_d = {NUM_REQ{~i_overflow_clear}} & (overflow_q | (rise_c & pending_q & ~clr_c));
  end

  // Edge history and event bookkeeping.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      prev_q     <= sync_q;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Grant FSM next-state: pick in IDLE, hold the offer steady until accepted.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = o_grant_valid;
    grant_idx_d   = o_grant_idx;
    rr_ptr_d      = rr_ptr_q;
    pick_c        = rr_pick(MAX_REQ'(pending_q), MAX_IDX_W'(rr_ptr_q), NUM_REQ);
    case (state_q)
      IDLE: begin
        if (pick_c.found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_c.idx == MAX_IDX_W'(i)) begin
              grant_idx_d = IDX_WIDTH'(i);
            end
          end
          grant_valid_d = 1'b1;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        if (i_grant_ready) begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
          if (32'(o_grant_idx) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = o_grant_idx + IDX_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // Grant FSM state and registered grant outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      o_grant_valid <= 1'b0;
      o_grant_idx   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      o_grant_valid <= grant_valid_d;
      o_grant_idx   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign o_pending  = pending_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_async_event_arbiter.sv
// Directed bench for async_event_arbiter with a cycle-level reference model.
module tb_async_event_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned SYNC_DEPTH = 2;
  localparam int unsigned IDX_WIDTH  = 2;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic [NUM_REQ-1:0]   i_async_req;
  logic                 o_grant_valid;
  logic [IDX_WIDTH-1:0] o_grant_idx;
  logic                 i_grant_ready;
  logic [NUM_REQ-1:0]   o_pending;
  logic [NUM_REQ-1:0]   o_overflow;
  logic                 i_overflow_clear;

  int n_chk  = 0;
  int n_fail = 0;

  async_event_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .SYNC_DEPTH (SYNC_DEPTH)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .i_async_req      (i_async_req),
    .o_grant_valid    (o_grant_valid),
    .o_grant_idx      (o_grant_idx),
    .i_grant_ready    (i_grant_ready),
    .o_pending        (o_pending),
    .o_overflow       (o_overflow),
    .i_overflow_clear (i_overflow_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples of each line per edge, events, pending, grants.
  logic [NUM_REQ-1:0] hist [SYNC_DEPTH+1];
  bit                 started = 1'b0;
  bit                 m_valid = 1'b0;
  int                 m_idx   = 0;
  int                 m_ptr   = 0;
  logic [NUM_REQ-1:0] m_pend  = '0;
  logic [NUM_REQ-1:0] m_ovf   = '0;

  always @(posedge clk) begin : model
    logic [NUM_REQ-1:0] ev;
    logic [NUM_REQ-1:0] taken;
    int                 pick;
    if (!n_rst) begin
      started = 1'b1;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_pend  = '0;
      m_ovf   = '0;
      for (int j = 0; j <= SYNC_DEPTH; j++) hist[j] = '0;
    end else if (started) begin
      // an event is a line seen high SYNC_DEPTH samples ago after being low the sample before
      ev    = hist[SYNC_DEPTH-1] & ~hist[SYNC_DEPTH];
      taken = '0;
      if (m_valid) begin
        if (i_grant_ready) begin
          taken[m_idx] = 1'b1;
          m_ptr   = (m_idx + 1) % NUM_REQ;
          m_valid = 1'b0;
        end
      end else begin
        pick = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (pick < 0 && m_pend[(m_ptr + k) % NUM_REQ]) pick = (m_ptr + k) % NUM_REQ;
        end
        if (pick >= 0) begin
          m_valid = 1'b1;
          m_idx   = pick;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        m_ovf[i]  = !i_overflow_clear && (m_ovf[i] || (ev[i] && m_pend[i] && !taken[i]));
        m_pend[i] = ev[i] || (m_pend[i] && !taken[i]);
      end
      for (int j = SYNC_DEPTH; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = i_async_req;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid",    32'(o_grant_valid), 32'(m_valid));
      chk("cyc_idx",      32'(o_grant_idx),   32'(m_idx));
      chk("cyc_pending",  32'(o_pending),     32'(m_pend));
      chk("cyc_overflow", 32'(o_overflow),    32'(m_ovf));
    end
  end

  // Record accepted grants as seen on the DUT interface.
  int grant_log[$];
  always @(posedge clk) begin
    if (n_rst === 1'b1 && o_grant_valid === 1'b1 && i_grant_ready === 1'b1)
      grant_log.push_back(int'(o_grant_idx));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int c = 0;
    while (o_grant_valid !== 1'b1 && c < max_cyc) begin
      step(1);
      c++;
    end
    chk(name, 32'(o_grant_valid), 32'd1);
  endtask

  task automatic check_log(input string name, input int n, input int e0, input int e1, input int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({name, "_len"}, 32'(grant_log.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < grant_log.size()) chk({name, "_idx"}, 32'(grant_log[k]), 32'(e[k]));
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    i_async_req = '0;
    i_grant_ready = 1'b0;
    i_overflow_clear = 1'b0;
    step(3);
    chk("rst_valid",    32'(o_grant_valid), 32'd0);
    chk("rst_idx",      32'(o_grant_idx),   32'd0);
    chk("rst_pending",  32'(o_pending),     32'd0);
    chk("rst_overflow", 32'(o_overflow),    32'd0);
    n_rst = 1'b1;
    step(1);
  endtask

  initial begin
    n_rst = 1'b0;
    i_async_req = '0;
    i_grant_ready = 1'b0;
    i_overflow_clear = 1'b0;
    @(negedge clk);
    do_reset();

    // Line 2 pulse: latency to pending and grant, then clear on accept.
    i_grant_ready = 1'b1;
    i_async_req = 4'b0100;
    step(1);
    chk("t1_pend_e0", 32'(o_pending), 32'h0);
    step(1);
    chk("t1_pend_e1", 32'(o_pending), 32'h0);
    step(1);
    chk("t1_pend_e2", 32'(o_pending), 32'h4);
    chk("t1_valid_e2", 32'(o_grant_valid), 32'd0);
    i_async_req = '0;
    step(1);
    chk("t1_valid_e3", 32'(o_grant_valid), 32'd1);
    chk("t1_idx_e3", 32'(o_grant_idx), 32'd2);
    step(1);
    chk("t1_valid_e4", 32'(o_grant_valid), 32'd0);
    chk("t1_pend_e4", 32'(o_pending), 32'h0);
    step(4);
    // Pointer now 3: lines 0 and 3 together are served 3 then 0.
    grant_log.delete();
    i_async_req = 4'b1001;
    step(10);
    check_log("t1_ptr3", 2, 3, 0, 0);
    i_async_req = '0;
    step(3);

    // Lines 0,1,3 at once from pointer 0.
    do_reset();
    grant_log.delete();
    i_grant_ready = 1'b1;
    i_async_req = 4'b1011;
    step(12);
    check_log("t2_order", 3, 0, 1, 3);
    i_async_req = '0;
    step(3);
    // Pointer wrapped to 0 after serving line 3.
    grant_log.delete();
    i_async_req = 4'b1001;
    step(10);
    check_log("t2_wrap", 2, 0, 3, 0);
    i_async_req = '0;
    step(3);

    // Held grant keeps its index while another line becomes pending.
    i_grant_ready = 1'b0;
    grant_log.delete();
    i_async_req = 4'b0010;
    wait_valid("t3_wait", 10);
    chk("t3_idx_first", 32'(o_grant_idx), 32'd1);
    i_async_req = 4'b1010;
    step(6);
    chk("t3_valid_hold", 32'(o_grant_valid), 32'd1);
    chk("t3_idx_hold", 32'(o_grant_idx), 32'd1);
    chk("t3_pend_both", 32'(o_pending), 32'ha);
    i_grant_ready = 1'b1;
    step(8);
    check_log("t3_order", 2, 1, 3, 0);
    i_async_req = '0;
    step(3);

    // Overflow: second event on a pending line, sticky, cleared, clear beats set.
    i_grant_ready = 1'b0;
    grant_log.delete();
    i_async_req = 4'b0001;
    step(2);
    i_async_req = '0;
    step(2);
    i_async_req = 4'b0001;
    step(4);
    chk("t4_ovf_set", 32'(o_overflow), 32'h1);
    step(3);
    chk("t4_ovf_sticky", 32'(o_overflow), 32'h1);
    i_overflow_clear = 1'b1;
    step(1);
    i_overflow_clear = 1'b0;
    chk("t4_ovf_cleared", 32'(o_overflow), 32'h0);
    i_async_req = '0;
    step(3);
    i_async_req = 4'b0001;
    step(2);
    i_overflow_clear = 1'b1;
    step(1);
    i_overflow_clear = 1'b0;
    chk("t4_clr_wins", 32'(o_overflow), 32'h0);
    chk("t4_pend_kept", 32'(o_pending), 32'h1);
    step(2);
    chk("t4_ovf_after", 32'(o_overflow), 32'h0);
    i_grant_ready = 1'b1;
    step(6);
    check_log("t4_grants", 1, 0, 0, 0);
    i_async_req = '0;
    step(3);

    // New event on line 2 lands on the same edge its grant is accepted.
    i_grant_ready = 1'b0;
    grant_log.delete();
    i_async_req = 4'b0100;
    step(2);
    i_async_req = '0;
    wait_valid("t5_wait", 10);
    chk("t5_idx", 32'(o_grant_idx), 32'd2);
    step(2);
    i_async_req = 4'b0100;
    step(2);
    i_grant_ready = 1'b1;
    step(1);
    chk("t5_pend_kept", 32'(o_pending), 32'h4);
    chk("t5_no_ovf", 32'(o_overflow), 32'h0);
    chk("t5_valid_gap", 32'(o_grant_valid), 32'd0);
    step(6);
    check_log("t5_grants", 2, 2, 2, 0);
    i_async_req = '0;
    step(3);

    // Reset while offering, line 1 held high across release.
    i_grant_ready = 1'b0;
    i_async_req = 4'b0010;
    wait_valid("t6_wait", 10);
    chk("t6_idx", 32'(o_grant_idx), 32'd1);
    n_rst = 1'b0;
    step(1);
    chk("t6_rst_valid", 32'(o_grant_valid), 32'd0);
    chk("t6_rst_idx", 32'(o_grant_idx), 32'd0);
    chk("t6_rst_pend", 32'(o_pending), 32'h0);
    chk("t6_rst_ovf", 32'(o_overflow), 32'h0);
    step(2);
    grant_log.delete();
    n_rst = 1'b1;
    i_grant_ready = 1'b1;
    step(12);
    check_log("t6_one_grant", 1, 1, 0, 0);
    i_async_req = '0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
